// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and default sizing for the serial adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit adder slice with carry-out and carry into its MSB
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum    = w_full[DIGIT-1:0];
    assign cout   = w_full[DIGIT];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign c_msb  = a[DIGIT-1] ^ b[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - digit-serial add/subtract unit processing DIGIT bits per clock
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder_n: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_carry;
    logic                   r_sub;
    logic                   r_cout;
    logic                   r_ovf;
    logic [CW-1:0]          r_cnt;

    logic                   w_accept;
    logic                   w_last;
    logic [DIGIT-1:0]       w_b_digit;
    logic [DIGIT-1:0]       w_dsum;
    logic                   w_dcout;
    logic                   w_dcmsb;
    logic [WIDTH+DIGIT-1:0] w_cat;

    assign w_accept  = (r_state != RUN) && start;
    assign w_last    = (r_cnt == LAST);
    // b is held as presented; the subtract inversion is applied per digit from the latched mode.
    assign w_b_digit = r_b[DIGIT-1:0] ^ {DIGIT{r_sub}};
    assign w_cat     = {w_dsum, r_sum};

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (r_a[DIGIT-1:0]),
        .b     (w_b_digit),
        .cin   (r_carry),
        .sum   (w_dsum),
        .cout  (w_dcout),
        .c_msb (w_dcmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= sub ? ~cin : cin;
            r_sub   <= sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dcout;
            r_sum   <= w_cat[WIDTH+DIGIT-1:DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_dcout;
                r_ovf  <= w_dcout ^ w_dcmsb;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - scoreboard bench for serial_adder_n (8/2 directed, 4/1 and 4/4 sweep)
module tb_serial_adder_n;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, sub, cin;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       s_start, s_sub, s_cin;
    logic [3:0] s_a, s_b;
    logic       busy1, done1, cout1, ovf1;
    logic [3:0] sum1;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    exp_t q_m[$];
    exp_t q1[$];
    exp_t q4[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder_n #(.WIDTH(4), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder_n #(.WIDTH(4), .DIGIT(4)) u_dut_d4 (
        .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q_m.size() == 0) begin
                chk("main_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q_m.pop_front();
                chk("main_sum", 32'(sum), 32'(e.s));
                chk("main_cout", 32'(cout), 32'(e.c));
                chk("main_ovf", 32'(ovf), 32'(e.o));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("d1_sum", 32'(sum1), 32'(e.s[3:0]));
                chk("d1_cout", 32'(cout1), 32'(e.c));
                chk("d1_ovf", 32'(ovf1), 32'(e.o));
            end
        end
    end

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("d4_sum", 32'(sum4), 32'(e.s[3:0]));
                chk("d4_cout", 32'(cout4), 32'(e.c));
                chk("d4_ovf", 32'(ovf4), 32'(e.o));
            end
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) chk("main_done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                         input logic icin, input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        @(negedge clk);
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        q_m.push_back('{es, ec, eo});
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_run", 32'(busy), 1);
        wait_done(cyc);
        chk("latency", 32'(cyc + 1), 5);
        @(negedge clk);
        @(negedge clk);
        chk("hold_sum", 32'(sum), 32'(es));
        chk("hold_cout", 32'(cout), 32'(ec));
        chk("hold_ovf", 32'(ovf), 32'(eo));
        chk("idle_not_busy", 32'(busy), 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_a = '0; s_b = '0;
        #2;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_sum", 32'(sum), 0);
        chk("reset_flags", 32'({cout, ovf}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'd100, 8'd27,  1'b0, 1'b0, 8'd127, 1'b0, 1'b0);
        do_op(8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1);
        do_op(8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0);
        do_op(8'd5,   8'd9,   1'b1, 1'b0, 8'd252, 1'b0, 1'b0);
        do_op(8'd9,   8'd5,   1'b1, 1'b1, 8'd3,   1'b1, 1'b0);
        do_op(8'd255, 8'd0,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0);
        do_op(8'd128, 8'd1,   1'b1, 1'b0, 8'd127, 1'b1, 1'b1);

        // Second start two cycles into RUN must be ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd20; sub = 1'b0; cin = 1'b0; start = 1'b1;
        q_m.push_back('{8'd30, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'd50; b = 8'd60; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        repeat (8) @(negedge clk);

        // Reset mid-RUN clears outputs at once and suppresses done.
        @(negedge clk);
        a = 8'd77; b = 8'd88; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_sum", 32'(sum), 0);
        chk("rst_mid_flags", 32'({cout, ovf}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_op(8'd1, 8'd1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);

        // Start held through DONE: second op must begin with no IDLE cycle.
        @(negedge clk);
        a = 8'd3; b = 8'd4; sub = 1'b0; cin = 1'b0; start = 1'b1;
        q_m.push_back('{8'd7, 1'b0, 1'b0});
        @(negedge clk);
        wait_done(cyc);
        a = 8'd128; b = 8'd128;
        q_m.push_back('{8'd0, 1'b1, 1'b1});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle_gap", 32'(busy), 1);
        wait_done(cyc);
        repeat (4) @(negedge clk);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic [3:0] va, vb;
                    logic       vc, eo;
                    logic [4:0] t;
                    va = 4'(ia); vb = 4'(ib); vc = 1'(ic);
                    t  = {1'b0, va} + {1'b0, vb} + {4'b0, vc};
                    eo = (va[3] == vb[3]) && (t[3] != va[3]);
                    @(negedge clk);
                    s_a = va; s_b = vb; s_cin = vc; s_start = 1'b1;
                    q1.push_back('{{4'b0, t[3:0]}, t[4], eo});
                    q4.push_back('{{4'b0, t[3:0]}, t[4], eo});
                    @(negedge clk);
                    s_start = 1'b0;
                    cyc = 0;
                    while ((q1.size() != 0 || q4.size() != 0) && cyc < 20) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (q1.size() != 0 || q4.size() != 0) begin
                        chk("sweep_timeout", 0, 1);
                        q1.delete();
                        q4.delete();
                    end
                end
            end
        end

        repeat (4) @(negedge clk);
        chk("queues_drained", 32'(q_m.size() + q1.size() + q4.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
